// File: rtl/riscv_core_wrapper.sv
// Simulation SoC wrapper: compact RV32I-subset core, byte-addressed dual-port RAM,
// and memory-mapped stdout / test-status / exit peripherals.

module load_store_unit (
    input  logic        req_i,
    input  logic        we_i,
    input  logic        byte_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o
);
    assign data_req_o   = req_i;
    assign data_we_o    = we_i;
    assign data_addr_o  = addr_i;
    assign data_be_o    = byte_i ? (4'b0001 << addr_i[1:0]) : 4'b1111;
    assign data_wdata_o = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
endmodule

module riscv_core #(
    parameter int INSTR_RDATA_WIDTH = 128,
    parameter int PULP_SECURE       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  boot_addr_i,
    input  logic                         fetch_enable_i,
    output logic                         instr_req_o,
    input  logic                         instr_gnt_i,
    input  logic                         instr_rvalid_i,
    output logic [31:0]                  instr_addr_o,
    input  logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_i,
    output logic                         data_req_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    output logic                         data_we_o,
    output logic [3:0]                   data_be_o,
    output logic [31:0]                  data_addr_o,
    output logic [31:0]                  data_wdata_o,
    input  logic [31:0]                  data_rdata_i
);
    // state   | meaning
    // S_BOOT  | load pc from boot_addr_i after reset
    // S_FETCH | instruction request at pc (held off while fetch_enable_i is low)
    // S_WAIT  | waiting for fetch data; latch the selected word
    // S_EXEC  | execute; loads/stores issue their data request here
    // S_MEM   | waiting for the data response; loads write back
    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_WAIT, S_EXEC, S_MEM} state_t;
    localparam int IW = INSTR_RDATA_WIDTH / 32;

    if (!(INSTR_RDATA_WIDTH == 32 || INSTR_RDATA_WIDTH == 128) || PULP_SECURE < 0 || PULP_SECURE > 1) begin : g_cfg_check
        $error("riscv_core: INSTR_RDATA_WIDTH must be 32 or 128 and PULP_SECURE 0 or 1");
    end

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, fetch_word;
    logic [31:0] rf [0:31];
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_u, imm_j, rs1_val, rs2_val, wb_val;
    logic        is_lui, is_addi, is_jal, is_load, is_store, is_mem, wb_alu, lsu_req;

    assign rd       = ir_q[11:7];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_u    = {ir_q[31:12], 12'h000};
    assign imm_j    = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign is_lui   = ir_q[6:0] == 7'b0110111;
    assign is_addi  = ir_q[6:0] == 7'b0010011 && ir_q[14:12] == 3'b000;
    assign is_jal   = ir_q[6:0] == 7'b1101111;
    assign is_load  = ir_q[6:0] == 7'b0000011;
    assign is_store = ir_q[6:0] == 7'b0100011;
    assign is_mem   = is_load || is_store;
    assign wb_alu   = is_lui || is_addi || is_jal;
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign wb_val   = is_lui ? imm_u : (is_addi ? rs1_val + imm_i : pc_q + 32'd4);
    assign instr_addr_o = pc_q;

    // Pick the 32-bit word addressed by pc out of the fetch line.
    always_comb begin
        fetch_word = instr_rdata_i[31:0];
        for (int i = 1; i < IW; i++)
            if (pc_q[3:2] == 2'(i)) fetch_word = instr_rdata_i[32*i +: 32];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (instr_req_o && instr_gnt_i) state_d = S_WAIT;
            S_WAIT:  if (instr_rvalid_i) state_d = S_EXEC;
            S_EXEC:  if (!is_mem) state_d = S_FETCH;
                     else if (data_gnt_i) state_d = S_MEM;
            S_MEM:   if (data_rvalid_i) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    // Output decode.
    always_comb begin
        instr_req_o = 1'b0;
        lsu_req     = 1'b0;
        case (state_q)
            S_FETCH: instr_req_o = fetch_enable_i;
            S_EXEC:  lsu_req     = is_mem;
            default: ;
        endcase
    end

    // Program counter and instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            if (state_q == S_BOOT) pc_q <= boot_addr_i;
            if (state_q == S_WAIT && instr_rvalid_i) ir_q <= fetch_word;
            if (state_q == S_EXEC && !is_mem) pc_q <= is_jal ? pc_q + imm_j : pc_q + 32'd4;
            if (state_q == S_MEM && data_rvalid_i) pc_q <= pc_q + 32'd4;
        end
    end

    // Register file write-back; x0 is never written.
    always_ff @(posedge clk) begin
        if (state_q == S_EXEC && wb_alu && rd != 5'd0)
            rf[rd] <= wb_val;
        else if (state_q == S_MEM && data_rvalid_i && is_load && rd != 5'd0)
            rf[rd] <= data_rdata_i;
    end

    load_store_unit load_store_unit_i (
        .req_i        (lsu_req),
        .we_i         (is_store),
        .byte_i       (is_store && ir_q[14:12] == 3'b000),
        .addr_i       (rs1_val + (is_store ? imm_s : imm_i)),
        .wdata_i      (rs2_val),
        .data_req_o   (data_req_o),
        .data_we_o    (data_we_o),
        .data_addr_o  (data_addr_o),
        .data_be_o    (data_be_o),
        .data_wdata_o (data_wdata_o)
    );
endmodule

module dp_ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         en_a_i,
    input  logic [ADDR_WIDTH-1:0]        addr_a_i,
    output logic [INSTR_RDATA_WIDTH-1:0] rdata_a_o,
    input  logic                         en_b_i,
    input  logic [ADDR_WIDTH-1:0]        addr_b_i,
    input  logic                         we_b_i,
    input  logic [3:0]                   be_b_i,
    input  logic [31:0]                  wdata_b_i,
    output logic [31:0]                  rdata_b_o
);
    localparam int NB = INSTR_RDATA_WIDTH / 8;

    logic [7:0]            mem [0:2**ADDR_WIDTH-1];
    logic [ADDR_WIDTH-1:0] base_a, base_b;

    assign base_a = addr_a_i & ~ADDR_WIDTH'(NB - 1);
    assign base_b = addr_b_i & ~ADDR_WIDTH'(3);

    // Both ports read the pre-edge contents, so a same-cycle fetch sees the old byte.
    always_ff @(posedge clk) begin
        if (en_a_i)
            for (int i = 0; i < NB; i++) rdata_a_o[8*i +: 8] <= mem[base_a + ADDR_WIDTH'(i)];
        if (en_b_i)
            for (int i = 0; i < 4; i++) begin
                rdata_b_o[8*i +: 8] <= mem[base_b + ADDR_WIDTH'(i)];
                if (we_b_i && be_b_i[i]) mem[base_b + ADDR_WIDTH'(i)] <= wdata_b_i[8*i +: 8];
            end
    end
endmodule

module ram #(
    parameter int ADDR_WIDTH        = 22,
    parameter int INSTR_RDATA_WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_req_i,
    input  logic [ADDR_WIDTH-1:0]        instr_addr_i,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
    output logic                         instr_rvalid_o,
    input  logic                         data_req_i,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_wdata_i,
    output logic [31:0]                  data_rdata_o
);
    dp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)) dp_ram_i (
        .clk       (clk),
        .en_a_i    (instr_req_i),
        .addr_a_i  (instr_addr_i),
        .rdata_a_o (instr_rdata_o),
        .en_b_i    (data_req_i),
        .addr_b_i  (data_addr_i),
        .we_b_i    (data_we_i),
        .be_b_i    (data_be_i),
        .wdata_b_i (data_wdata_i),
        .rdata_b_o (data_rdata_o)
    );

    // Fetch response follows the grant by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instr_rvalid_o <= 1'b0;
        else        instr_rvalid_o <= instr_req_i;
    end
endmodule

module riscv_core_wrapper #(
    parameter int          INSTR_RDATA_WIDTH = 128,
    parameter int          RAM_ADDR_WIDTH    = 22,
    parameter logic [31:0] BOOT_ADDR         = 32'h80,
    parameter int          PULP_SECURE       = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_enable_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    logic                         instr_req, instr_gnt, instr_rvalid;
    logic [31:0]                  instr_addr;
    logic [INSTR_RDATA_WIDTH-1:0] instr_rdata;
    logic                         data_req, data_gnt, data_rvalid, data_we;
    logic [3:0]                   data_be;
    logic [31:0]                  data_addr, data_wdata, data_rdata, ram_rdata;
    logic                         data_is_ram, data_ram_q, status_wr, exit_wr, unused_instr_hi;

    assign instr_gnt       = instr_req;
    assign data_gnt        = data_req;
    assign data_is_ram     = data_addr[31:RAM_ADDR_WIDTH] == '0;
    assign status_wr       = data_req && data_we && data_addr == 32'h2000_0000;
    assign exit_wr         = data_req && data_we && data_addr == 32'h2000_0004;
    assign data_rdata      = data_ram_q ? ram_rdata : 32'd0;
    assign unused_instr_hi = ^instr_addr[31:RAM_ADDR_WIDTH];

    riscv_core #(.INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH), .PULP_SECURE(PULP_SECURE)) riscv_core_i (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_addr_i    (BOOT_ADDR),
        .fetch_enable_i (fetch_enable_i),
        .instr_req_o    (instr_req),
        .instr_gnt_i    (instr_gnt),
        .instr_rvalid_i (instr_rvalid),
        .instr_addr_o   (instr_addr),
        .instr_rdata_i  (instr_rdata),
        .data_req_o     (data_req),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .data_we_o      (data_we),
        .data_be_o      (data_be),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_rdata_i   (data_rdata)
    );

    ram #(.ADDR_WIDTH(RAM_ADDR_WIDTH), .INSTR_RDATA_WIDTH(INSTR_RDATA_WIDTH)) ram_i (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr[RAM_ADDR_WIDTH-1:0]),
        .instr_rdata_o  (instr_rdata),
        .instr_rvalid_o (instr_rvalid),
        .data_req_i     (data_req && data_is_ram),
        .data_addr_i    (data_addr[RAM_ADDR_WIDTH-1:0]),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_rdata_o   (ram_rdata)
    );

    // Data response, status pulses and exit code, all one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_rvalid    <= 1'b0;
            data_ram_q     <= 1'b0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            data_rvalid    <= data_req;
            data_ram_q     <= data_req && data_is_ram && !data_we;
            tests_passed_o <= status_wr && data_wdata == 32'd123456789;
            tests_failed_o <= status_wr && data_wdata == 32'd1;
            exit_valid_o   <= exit_wr;
            if (exit_wr) exit_value_o <= data_wdata;
        end
    end

`ifndef SYNTHESIS
    // Echo firmware console output to the simulator log.
    always_ff @(posedge clk) begin
        if (data_req && data_we && data_addr == 32'h1000_0000) $write("%c", data_wdata[7:0]);
    end
`endif
endmodule

// File: tb/tb_riscv_core_wrapper.sv
// Directed bench for riscv_core_wrapper: small firmware images are loaded into the
// RAM through the hierarchy and the status/exit outputs and bus timing are checked.

module tb_riscv_core_wrapper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable = 1'b0;
    logic        tests_passed, tests_failed, exit_valid;
    logic [31:0] exit_value;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog [$];

    int          pass_cnt, fail_cnt, exit_cnt, pass_cyc, fail_cyc, exit_cyc, status_wr_cyc, exit_wr_cyc;
    logic [31:0] exit_vals [0:3];
    logic [31:0] watch_addr;
    bit          w_seen, f_seen, ff_seen;
    logic        w_rvalid;
    logic [31:0] w_rdata, first_fetch;
    logic [127:0] f_rdata;

    riscv_core_wrapper #(
        .INSTR_RDATA_WIDTH (128),
        .RAM_ADDR_WIDTH    (22),
        .BOOT_ADDR         (32'h80),
        .PULP_SECURE       (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fetch_enable),
        .tests_passed_o (tests_passed),
        .tests_failed_o (tests_failed),
        .exit_valid_o   (exit_valid),
        .exit_value_o   (exit_value)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] st(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    localparam logic [31:0] HALT = 32'h0000_006F;

    // Loads prog at 0x80 while reset is held low.
    task automatic load_prog();
        rst_n = 1'b0;
        fetch_enable = 1'b1;
        for (int a = 'h80; a < 'h180; a++) dut.ram_i.dp_ram_i.mem[22'(a)] = 8'h00;
        foreach (prog[i])
            for (int b = 0; b < 4; b++) dut.ram_i.dp_ram_i.mem[22'('h80 + 4*i + b)] = prog[i][8*b +: 8];
    endtask

    task automatic run_prog(input int ncyc);
        bit w_arm, w_prev, f_arm, f_prev;
        pass_cnt = 0; fail_cnt = 0; exit_cnt = 0;
        pass_cyc = -1; fail_cyc = -1; exit_cyc = -1; status_wr_cyc = -1; exit_wr_cyc = -1;
        w_seen = 0; f_seen = 0; ff_seen = 0; w_arm = 0; w_prev = 0; f_arm = 0; f_prev = 0;
        w_rvalid = 1'b0; w_rdata = '0; f_rdata = '0; first_fetch = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (w_prev) begin w_seen = 1; w_rvalid = dut.data_rvalid; w_rdata = dut.data_rdata; end
            if (f_prev) begin f_seen = 1; f_rdata = dut.instr_rdata; end
            w_prev = 0; f_prev = 0;
            if (dut.instr_req && !ff_seen) begin ff_seen = 1; first_fetch = dut.instr_addr; end
            if (dut.instr_req && dut.instr_addr == 32'h84 && !f_arm) begin f_arm = 1; f_prev = 1; end
            if (dut.data_req && !dut.data_we && !w_arm &&
                dut.riscv_core_i.load_store_unit_i.data_addr_o == watch_addr) begin w_arm = 1; w_prev = 1; end
            if (dut.data_req && dut.data_we && status_wr_cyc < 0 &&
                dut.riscv_core_i.load_store_unit_i.data_addr_o == 32'h2000_0000) status_wr_cyc = k;
            if (dut.data_req && dut.data_we && exit_wr_cyc < 0 &&
                dut.riscv_core_i.load_store_unit_i.data_addr_o == 32'h2000_0004) exit_wr_cyc = k;
            if (tests_passed) begin if (pass_cnt == 0) pass_cyc = k; pass_cnt++; end
            if (tests_failed) begin if (fail_cnt == 0) fail_cyc = k; fail_cnt++; end
            if (exit_valid) begin
                if (exit_cnt == 0) exit_cyc = k;
                if (exit_cnt < 4) exit_vals[exit_cnt] = exit_value;
                exit_cnt++;
            end
        end
    endtask

    task automatic set_pass_prog();
        prog = {lui(5'd1, 20'h20000), lui(5'd2, 20'h075BD), addi(5'd2, 5'd2, 12'hD15),
                st(3'b010, 5'd2, 5'd1, 12'h000), HALT};
    endtask

    task automatic test_reset();
        set_pass_prog();
        load_prog();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if ({tests_passed, tests_failed, exit_valid, exit_value, dut.data_rvalid} !== 36'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got p=%b f=%b e=%b v=%0h rv=%b, expected all 0",
                         k, tests_passed, tests_failed, exit_valid, exit_value, dut.data_rvalid);
            end
        end
        rst_n = 1'b1;
        watch_addr = 32'hFFFF_FFFF;
        run_prog(20);
        n_tests++;
        if (!ff_seen || first_fetch !== 32'h80) begin
            n_fail++; $display("FAIL boot_fetch: got seen=%b addr=%0h, expected 80", ff_seen, first_fetch);
        end
    endtask

    task automatic test_pass();
        logic [127:0] exp_line;
        set_pass_prog();
        exp_line = {prog[3], prog[2], prog[1], prog[0]};
        load_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_addr = 32'hFFFF_FFFF;
        run_prog(80);
        n_tests++;
        if (pass_cnt != 1) begin n_fail++; $display("FAIL pass_pulse_count: got %0d expected 1", pass_cnt); end
        n_tests++;
        if (fail_cnt != 0) begin n_fail++; $display("FAIL pass_no_fail: got %0d expected 0", fail_cnt); end
        n_tests++;
        if (pass_cyc != status_wr_cyc + 1) begin
            n_fail++; $display("FAIL pass_timing: pulse cycle %0d, expected %0d", pass_cyc, status_wr_cyc + 1);
        end
        n_tests++;
        if (!f_seen || f_rdata !== exp_line) begin
            n_fail++; $display("FAIL fetch_line_84: got seen=%b %032h expected %032h", f_seen, f_rdata, exp_line);
        end
    endtask

    task automatic test_fail_status();
        prog = {lui(5'd1, 20'h20000), addi(5'd2, 5'd0, 12'd1), st(3'b010, 5'd2, 5'd1, 12'h000),
                addi(5'd3, 5'd0, 12'd5), st(3'b010, 5'd3, 5'd1, 12'h000), HALT};
        load_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_addr = 32'hFFFF_FFFF;
        run_prog(80);
        n_tests++;
        if (fail_cnt != 1) begin n_fail++; $display("FAIL fail_pulse_count: got %0d expected 1", fail_cnt); end
        n_tests++;
        if (pass_cnt != 0) begin n_fail++; $display("FAIL fail_no_pass: got %0d expected 0", pass_cnt); end
        n_tests++;
        if (fail_cyc != status_wr_cyc + 1) begin
            n_fail++; $display("FAIL fail_timing: pulse cycle %0d, expected %0d", fail_cyc, status_wr_cyc + 1);
        end
    endtask

    task automatic test_exit();
        prog = {lui(5'd1, 20'h20000), st(3'b010, 5'd0, 5'd1, 12'h004), addi(5'd3, 5'd0, 12'd3),
                st(3'b010, 5'd3, 5'd1, 12'h004), HALT};
        load_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_addr = 32'hFFFF_FFFF;
        run_prog(80);
        n_tests++;
        if (exit_cnt != 2) begin n_fail++; $display("FAIL exit_count: got %0d expected 2", exit_cnt); end
        n_tests++;
        if (exit_vals[0] !== 32'd0) begin n_fail++; $display("FAIL exit_value_0: got %0h expected 0", exit_vals[0]); end
        n_tests++;
        if (exit_vals[1] !== 32'd3) begin n_fail++; $display("FAIL exit_value_3: got %0h expected 3", exit_vals[1]); end
        n_tests++;
        if (exit_value !== 32'd3) begin n_fail++; $display("FAIL exit_value_hold: got %0h expected 3", exit_value); end
        n_tests++;
        if (exit_cyc != exit_wr_cyc + 1) begin
            n_fail++; $display("FAIL exit_timing: pulse cycle %0d, expected %0d", exit_cyc, exit_wr_cyc + 1);
        end
    endtask

    task automatic set_byte_prog();
        prog = {lui(5'd1, 20'h00200), addi(5'd2, 5'd0, 12'h0AB), st(3'b000, 5'd2, 5'd1, 12'h001),
                lw(5'd5, 5'd1, 12'h000), lui(5'd4, 20'h20000), st(3'b010, 5'd5, 5'd4, 12'h004), HALT};
        load_prog();
        dut.ram_i.dp_ram_i.mem[22'h200000] = 8'h44;
        dut.ram_i.dp_ram_i.mem[22'h200001] = 8'h33;
        dut.ram_i.dp_ram_i.mem[22'h200002] = 8'h22;
        dut.ram_i.dp_ram_i.mem[22'h200003] = 8'h11;
    endtask

    task automatic test_byte_store();
        set_byte_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_addr = 32'h0020_0000;
        run_prog(80);
        n_tests++;
        if (!w_seen || w_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL byte_load_rvalid: got seen=%b rvalid=%b expected 1", w_seen, w_rvalid);
        end
        n_tests++;
        if (w_rdata !== 32'h1122_AB44) begin n_fail++; $display("FAIL byte_load_rdata: got %0h expected 1122ab44", w_rdata); end
        n_tests++;
        if (exit_value !== 32'h1122_AB44) begin n_fail++; $display("FAIL byte_exit_value: got %0h expected 1122ab44", exit_value); end
    endtask

    task automatic test_unmapped();
        prog = {lui(5'd6, 20'h30000), addi(5'd7, 5'd0, 12'd9), lw(5'd7, 5'd6, 12'h000),
                lui(5'd4, 20'h20000), st(3'b010, 5'd7, 5'd4, 12'h004), HALT};
        load_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_addr = 32'h3000_0000;
        run_prog(80);
        n_tests++;
        if (!w_seen || w_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL unmapped_rvalid: got seen=%b rvalid=%b expected 1", w_seen, w_rvalid);
        end
        n_tests++;
        if (w_rdata !== 32'd0) begin n_fail++; $display("FAIL unmapped_rdata: got %0h expected 0", w_rdata); end
        n_tests++;
        if (exit_cnt != 1 || exit_vals[0] !== 32'd0) begin
            n_fail++; $display("FAIL unmapped_exit: got count=%0d value=%0h expected 1 / 0", exit_cnt, exit_vals[0]);
        end
    endtask

    task automatic test_reset_mid_access();
        bit found = 0;
        set_byte_prog();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (dut.data_req) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++; $display("FAIL midrst_no_request: got none within 60 cycles, expected a data request");
        end else begin
            @(negedge clk);
            n_tests++;
            if (dut.data_rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: got rvalid=%b expected 1", dut.data_rvalid); end
            rst_n = 1'b0;
            #1;
            n_tests++;
            if (dut.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_drop: got rvalid=%b expected 0", dut.data_rvalid); end
            @(posedge clk);
            #1;
            n_tests++;
            if (dut.data_rvalid !== 1'b0 || exit_valid !== 1'b0) begin
                n_fail++; $display("FAIL midrst_hold: got rvalid=%b exit=%b expected 0/0", dut.data_rvalid, exit_valid);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_status();
        test_exit();
        test_byte_store();
        test_unmapped();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_core_wrapper.md
# riscv_core_wrapper

Simulation-level SoC wrapper around the RI5CY `riscv_core`: a byte-addressed dual-port RAM for instructions and data, plus memory-mapped test-status, exit and stdout peripherals. It sits directly under the testbench top level and is the only block the testbench instantiates. The testbench preloads firmware into the RAM array through the hierarchy, holds reset, and then watches the status outputs.

## Interface
- INSTR_RDATA_WIDTH, 128: instruction fetch data width. Only 32 or 128 is legal.
- RAM_ADDR_WIDTH, 22: RAM byte-address width. The RAM holds 2^RAM_ADDR_WIDTH bytes (4 MiB).
- BOOT_ADDR, 'h80: boot address passed to the core.
- PULP_SECURE, 0: passed to the core. The testbench uses 1.
- Clock and reset (already decided): reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_enable_i  in  1  core fetch enable, passed through to the core.
- tests_passed_o  out  1  one-cycle pulse: test pass was signalled.
- tests_failed_o  out  1  one-cycle pulse: test fail was signalled.
- exit_valid_o  out  1  one-cycle pulse: firmware exit was signalled.
- exit_value_o  out  32  exit code, held until the next exit write.

## Operation
- Required hierarchy, used by the testbench through hierarchical references:
  - Core instance `riscv_core_i`, containing `load_store_unit_i.data_addr_o`.
  - Wrapper-level nets `data_req` and `data_we`.
  - Memory instance `ram_i` containing `dp_ram_i`, whose byte array `mem[0:2^RAM_ADDR_WIDTH-1]` must be loadable by `$readmemh`.
- Instruction port (fetch only):
  - Address = instr_addr[RAM_ADDR_WIDTH-1:0], aligned down to INSTR_RDATA_WIDTH/8 bytes.
  - Returns INSTR_RDATA_WIDTH/8 bytes, little-endian; the byte at the lowest address lands in rdata[7:0].
- Data port: 32-bit data, 4-bit byte enable, read/write request (data_req, data_we). Decode on the full 32-bit address:
  - Below 2^RAM_ADDR_WIDTH: RAM. Writes update only the enabled bytes. Reads return the 4 bytes at addr & ~3.
  - 0x1000_0000, write: stdout. The simulation prints wdata[7:0] as a character with `$write`. This path is excluded from synthesis.
  - 0x2000_0000, write: test status. wdata == 123456789 (0x075B_CD15) pulses tests_passed_o. wdata == 1 pulses tests_failed_o. Any other value has no effect.
  - 0x2000_0004, write: exit. Pulses exit_valid_o and loads exit_value_o with wdata.
  - Any other address: writes are ignored, reads return 0.
- Every accepted data request produces a response (rvalid), including peripheral and unmapped accesses.
- Peripheral reads return 0.
- The memory itself does not arbitrate: the two ports are independent.
- When both ports touch the same byte in the same cycle, the data write is applied after the instruction read. The fetch sees the old value.

## Timing
- Both ports grant combinationally: gnt = req, in the same cycle.
- rdata and rvalid are registered and appear exactly 1 cycle after the grant.
- Back-to-back requests are accepted every cycle.
- RAM and peripheral writes take effect at the granting clock edge.
- Status pulse timing: tests_passed_o, tests_failed_o and exit_valid_o are registered. Each is high for exactly the one cycle following the granting edge.
- exit_value_o updates at that same edge and holds its value afterwards.
- Reset values: all outputs 0, exit_value_o = 0, rvalid = 0.
- RAM contents are not affected by reset. This lets the testbench preload before releasing reset.
- Reset asserted mid-access drops any pending rvalid immediately. No response is delivered after reset.
- Two status writes in consecutive cycles produce two consecutive pulses.

## Test plan
- Reset held for 4 cycles -> all outputs 0 throughout. Core starts fetching at BOOT_ADDR 0x80 after rst_n rises.
- Preload RAM with a program that writes 123456789 to 0x2000_0000 -> tests_passed_o high for exactly one cycle. tests_failed_o stays 0.
- Program writes 1 to 0x2000_0000 -> tests_failed_o pulses. Writing 5 to the same address -> no pulse.
- Program writes 0 to 0x2000_0004 -> exit_valid_o pulses and exit_value_o = 0. Writing 3 -> exit_value_o = 3, and it holds after the pulse.
- Byte store 0xAB to RAM 0x200001 (be = 0010), then word load from 0x200000 -> rdata[15:8] = 0xAB with the other bytes unchanged. rvalid arrives 1 cycle after the grant.
- 128-bit fetch from 0x84 with the RAM preloaded -> 16 bytes from 0x80–0x8F, little-endian. Load from unmapped 0x3000_0000 -> rdata 0 with rvalid asserted.
